// File: rtl/spi_frame_sequencer_if.sv
// spi_frame_sequencer_if: downstream sample stream (valid/ready) of spi_frame_sequencer.
interface spi_frame_sequencer_if;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    modport master (output sample_out, sample_valid, input sample_ready);
    modport slave (input sample_out, sample_valid, output sample_ready);
endinterface

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: drives fixed ADC SPI frames and queues one captured sample per period.
// Define SPI_SIGNED_CONV_EN to invert bit 15 at capture (offset-binary to two's complement).
module spi_frame_sequencer #(
    parameter int FRAME_LEN = 32,
    parameter int PERIOD = 64,
    parameter int DEPTH = 4
) (
    input  logic                    serial_clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    chip_select,
    input  logic [15:0]             rx_data,
    input  logic                    clear_overrun,
    output logic                    overrun,
    output logic [$clog2(DEPTH):0]  fill_level,
    spi_frame_sequencer_if.master   smp
);
    localparam int CW = $clog2(PERIOD);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic cs_n, wrap, push, pop, full, accept, drop;
    logic [15:0] push_data, last_out;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign wrap = cnt == CW'(PERIOD - 1);
    // chip_select is registered, so it is derived from the next state/count
    always_comb begin
        state_n = state;
        cnt_n = '0;
        if (state == IDLE) begin
            state_n = enable ? RUN : IDLE;
        end else begin
            cnt_n = wrap ? '0 : cnt + CW'(1);
            state_n = (wrap && !enable) ? IDLE : RUN;
        end
        cs_n = !(state_n == RUN && cnt_n < CW'(FRAME_LEN));
    end
`ifdef SPI_SIGNED_CONV_EN
    assign push_data = {~rx_data[15], rx_data[14:0]};
`else
    assign push_data = rx_data;
`endif
    assign push = state == RUN && cnt == CW'(FRAME_LEN);
    assign full = fill_level == FULL_LVL;
    assign smp.sample_valid = fill_level != '0;
    assign pop = smp.sample_valid && smp.sample_ready;
    assign accept = push && (!full || pop);
    assign drop = push && full && !pop;
    // last_out keeps the most recently popped sample visible while empty
    assign smp.sample_out = smp.sample_valid ? mem[rd_ptr] : last_out;
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            chip_select <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_level <= '0;
            overrun <= 1'b0;
            last_out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            chip_select <= cs_n;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_out <= mem[rd_ptr];
            end
            if (accept && !pop)
                fill_level <= fill_level + 1'b1;
            else if (pop && !accept)
                fill_level <= fill_level - 1'b1;
            if (drop)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end
    always_ff @(posedge serial_clk) begin
        if (accept)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer: randomized bench for spi_frame_sequencer against a queue-based period model.
module tb_spi_frame_sequencer;
    localparam int FRAME_LEN = 32;
    localparam int PERIOD = 64;
    localparam int DEPTH = 4;
    logic serial_clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear_overrun = 1'b0;
    logic chip_select, overrun;
    logic [15:0] rx_data = '0;
    logic [$clog2(DEPTH):0] fill_level;
    spi_frame_sequencer_if smp();
    spi_frame_sequencer #(.FRAME_LEN(FRAME_LEN), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
        .serial_clk(serial_clk),
        .reset(reset),
        .enable(enable),
        .chip_select(chip_select),
        .rx_data(rx_data),
        .clear_overrun(clear_overrun),
        .overrun(overrun),
        .fill_level(fill_level),
        .smp(smp)
    );
    always #5 serial_clk = ~serial_clk;
    // spi_receiver stand-in: shifts tx_word MSB first while chip_select is low
    logic [15:0] tx_word = '0, rx_shift = '0;
    logic [4:0] rx_bits = '0;
    always @(posedge serial_clk) begin
        if (chip_select) begin
            rx_bits <= '0;
        end else if (rx_bits < 5'd16) begin
            rx_shift <= {rx_shift[14:0], tx_word[~rx_bits[3:0]]};
            if (rx_bits == 5'd15)
                rx_data <= {rx_shift[14:0], tx_word[0]};
            rx_bits <= rx_bits + 5'd1;
        end
    end
    int tests = 0, errors = 0;
    bit running = 0, ovr = 0, use_fixed = 0;
    int pos = 0;
    logic [15:0] q[$];
    logic [15:0] last = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [15:0] conv(input logic [15:0] w);
`ifdef SPI_SIGNED_CONV_EN
        return w ^ 16'h8000;
`else
        return w;
`endif
    endfunction
    // called at a negedge: drive inputs, compare, advance the model one period slot
    task automatic step(input bit en, input bit rdy, input bit clr);
        bit pop, cap, drop;
        enable = en;
        smp.sample_ready = rdy;
        clear_overrun = clr;
        if (!running || pos == PERIOD - 1)
            tx_word = use_fixed ? 16'hA5C3 : 16'($urandom);
        check("chip_select", chip_select, !(running && pos < FRAME_LEN));
        check("sample_valid", smp.sample_valid, q.size() != 0);
        check("fill_level", fill_level, q.size());
        check("overrun", overrun, ovr);
        check("sample_out", smp.sample_out, q.size() != 0 ? q[0] : last);
        pop = q.size() != 0 && rdy;
        cap = running && pos == FRAME_LEN;
        if (pop)
            last = q.pop_front();
        drop = cap && q.size() >= DEPTH;
        if (cap && !drop)
            q.push_back(conv(tx_word));
        ovr = drop ? 1'b1 : (clr ? 1'b0 : ovr);
        if (running) begin
            if (pos == PERIOD - 1) begin
                pos = 0;
                running = en;
            end else begin
                pos++;
            end
        end else if (en) begin
            running = 1;
        end
        @(negedge serial_clk);
    endtask
    task automatic pulse_reset();
        reset = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_chip_select", chip_select, 1'b1);
        check("rst_sample_valid", smp.sample_valid, 1'b0);
        check("rst_fill_level", fill_level, 0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_sample_out", smp.sample_out, 16'h0000);
        running = 0;
        pos = 0;
        q.delete();
        last = '0;
        ovr = 0;
        repeat (3) @(negedge serial_clk);
        reset = 1'b1;
    endtask
    initial begin
        smp.sample_ready = 1'b0;
        #2 pulse_reset();
        use_fixed = 1;
        repeat (3 * PERIOD) step(1, 1, 0);
        use_fixed = 0;
        repeat (5 * PERIOD) step(1, 0, 0);
        while (pos != FRAME_LEN) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        repeat (4 * PERIOD) step(1, pos == FRAME_LEN, 0);
        repeat (10) step(1, 1, 0);
        while (pos != 5) step(1, 1, 0);
        repeat (2 * PERIOD) step(0, 1, 0);
        repeat (3) step(1, 1, 0);
        while (pos != 10) step(1, 1, 0);
        pulse_reset();
        repeat (2 * PERIOD) step(1, 1, 0);
        repeat (3000) step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Frame controller for the ADC SPI link, sharing `serial_clk` with `spi_receiver`. It drives the receiver's `chip_select` with a fixed frame and period, and captures the receiver's `data_out` once every frame. Captured samples are queued in a small FIFO and presented downstream with a valid/ready handshake. This block therefore sits both upstream of `spi_receiver` (it drives the frame) and downstream of it (it consumes the sample).

## Interface
Parameters:
- `FRAME_LEN`, 32: number of `serial_clk` cycles `chip_select` is held low per frame; legal range 17 to 32.
- `PERIOD`, 64: total `serial_clk` cycles per sample period; must be at least `FRAME_LEN`+2.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- `serial_clk` in, 1: the single clock; all logic is on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `enable` in, 1: run frames while high.
- `chip_select` out, 1: active-low frame strobe to `spi_receiver`; registered.
- `rx_data` in, 16: the receiver's `data_out`.
- `sample_out` out, 16: FIFO head.
- `sample_valid` out, 1: FIFO non-empty.
- `sample_ready` in, 1: downstream accepts the head.
- `clear_overrun` in, 1: synchronous clear of `overrun`.
- `overrun` out, 1: sticky flag, set when a sample is dropped.
- `fill_level` out, $clog2(`DEPTH`)+1: current FIFO occupancy.

## Operation
- State machine:
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE only at period wrap (`cnt`=`PERIOD`-1) with `enable`=0.
  - Deasserting `enable` mid-period completes the current period, including capture.
- Period counter `cnt` runs 0 to `PERIOD`-1 in RUN and wraps to 0. It is held at 0 in IDLE.
- `chip_select` is registered: 0 during cycles with `cnt` in [0, `FRAME_LEN`-1] in RUN, otherwise 1.
- The receiver completes its 16th bit at the edge ending `cnt`=15. `rx_data` is stable from `cnt`=16 until the next frame.
- Capture happens at the edge ending `cnt`=`FRAME_LEN`, which is the first cycle `chip_select`=1.
  - Capture is a FIFO push of `rx_data`. No capture occurs in IDLE.
- FIFO:
  - Circular buffer with wrapping read/write pointers, depth `DEPTH`.
  - A pop occurs on `sample_valid` && `sample_ready`.
  - `sample_out` shows the head combinationally from storage. It holds its last value when the FIFO is empty and is 0 after reset.
- Full with a push:
  - If a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
  - Otherwise the new sample is dropped, the stored data is untouched, and `overrun` is set.
- Empty with a push and `sample_ready` in the same cycle: there is no pop. The sample becomes visible the next cycle (no bypass).
- `overrun`: `clear_overrun` and a drop in the same cycle leave it set (set wins).
- Reset, asserted asynchronously (including mid-frame):
  - `chip_select`=1, `sample_valid`=0, `sample_out`=0, `overrun`=0, `fill_level`=0.
  - State=IDLE, `cnt`=0, pointers=0.
  - The partial frame is abandoned; the receiver clears on `chip_select` high.

## Timing
- `enable` rises before edge E0. State becomes RUN and `chip_select` goes 0 after E0.
- `chip_select` stays low for exactly `FRAME_LEN` cycles, then stays high for `PERIOD`-`FRAME_LEN` cycles.
- Sample latency: `sample_valid` rises one cycle after the capture edge, i.e. `FRAME_LEN`+1 cycles after `chip_select` falls.
- Throughput: one sample per `PERIOD` cycles.
- Pop: `fill_level` decrements at the same edge. The next head is visible in the following cycle.

## Configuration
- `SPI_SIGNED_CONV_EN` defined:
  - Bit 15 of `rx_data` is inverted at capture, converting offset-binary ADC codes to two's complement.
  - Example: 16'h8000 is stored as 16'h0000, and 16'h0000 as 16'h8000.
- Not defined: `rx_data` is stored unmodified.
- The FIFO, timing and handshake are identical in both builds.

## Test plan
- Reset, then `enable`=1 with defaults: `chip_select` is low for 32 cycles and high for 32, repeating. The first `sample_valid` appears 33 cycles after the first fall.
- Receiver model shifting 16'hA5C3, `sample_ready`=1: `sample_out`=16'hA5C3 (16'h25C3 with `SPI_SIGNED_CONV_EN`) for one cycle, then `fill_level` returns to 0.
- `sample_ready`=0 for 5 periods with `DEPTH`=4: 4 samples are held in order, the 5th is dropped, and `overrun`=1. `clear_overrun` then clears it, unless a drop occurs in that same cycle.
- FIFO full with a pop coincident with capture: the push is accepted, `fill_level` stays at 4 and `overrun` stays 0.
- `enable` dropped at `cnt`=5: the frame completes, the sample is captured, and the block goes IDLE at wrap with `chip_select`=1.
- `reset` pulsed low at `cnt`=10: immediately `chip_select`=1, `sample_valid`=0 and `fill_level`=0. After release, no stray sample is captured.
